// File: rtl/stage_pkg.sv
// Shared definitions for the stage_B -> stage_C pipeline example.
// Holds the output FSM encodings, the default data width and the handshake
// timing constants both stages are written against.
package stage_pkg;

  // Output FSM of stage_c: IDLE is always visited between two presented items.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } out_state_t;

  // Default data width shared by stage_B and stage_C.
  localparam int unsigned STAGE_WIDTH_DEFAULT = 8;

  // Handshake timing: the consumer raises its capture acknowledge for exactly
  // one cycle; the producer keeps its ready high during that cycle and drops
  // it on the following edge; presented outputs are at least two cycles apart.
  localparam int unsigned ACK_PULSE_CYCLES    = 1;
  localparam int unsigned DIR_HOLD_AFTER_ACK  = 1;
  localparam int unsigned MIN_OUTPUT_SPACING  = 2;

endpackage

// File: rtl/stage_fifo.sv
// Small synchronous FIFO used by stage_c as its input buffer.
// rdata is a register loaded with the head entry on pop; level alone tells
// full and empty, and pointers wrap modulo DEPTH (a power of two).
module stage_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [WIDTH-1:0] rdata_r;

  // Storage write: the entry at wr_ptr is overwritten on push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer, occupancy and read-register update; a pop reads the old head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      rdata_r  <= {WIDTH{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        rdata_r  <= mem_r[rd_ptr_r];
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = rdata_r;
  assign level = level_r;

endmodule

// File: rtl/stage_c.sv
// stage_c: consumer stage downstream of stage_B.
// Captures items over DIR/ack_prev into a FIFO, scales each by SCALE and
// presents it on DOR/ack_from_next. Build option STAGE_C_SATURATE_EN clamps
// the scaled value to all-ones instead of keeping its low WIDTH bits.
module stage_c
  import stage_pkg::*;
#(
  parameter int unsigned WIDTH = STAGE_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SCALE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   DIR,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   ack_prev,
  output logic                   DOR,
  output logic [WIDTH-1:0]       data_out,
  input  logic                   ack_from_next,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  // Scale in double width, then reduce to WIDTH bits (clamp or wrap).
  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] x);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, x} * (2*WIDTH)'(SCALE);
`ifdef STAGE_C_SATURATE_EN
    if (prod > {{WIDTH{1'b0}}, {WIDTH{1'b1}}}) begin
      return {WIDTH{1'b1}};
    end else begin
      return prod[WIDTH-1:0];
    end
`else
    return prod[WIDTH-1:0];
`endif
  endfunction

  out_state_t       state_r;
  logic             ack_prev_r;
  logic             dor_r;
  logic             cap_s;
  logic             pop_s;
  logic [WIDTH-1:0] head_s;
  logic [LW-1:0]    level_s;

  // Capture and pop decisions; the !ack_prev guard stops a second capture
  // of the item the producer is still holding during the ack cycle.
  always_comb begin
    cap_s = 1'b0;
    pop_s = 1'b0;
    if (DIR && !ack_prev_r && (level_s < LVL_FULL)) begin
      cap_s = 1'b1;
    end else begin
      cap_s = 1'b0;
    end
    if ((state_r == IDLE) && (level_s != {LW{1'b0}})) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  stage_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cap_s),
    .pop   (pop_s),
    .wdata (data_in),
    .rdata (head_s),
    .level (level_s)
  );

  // One-cycle acknowledge following each capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_prev_r <= 1'b0;
    end else begin
      ack_prev_r <= cap_s;
    end
  end

  // Output FSM: pop in IDLE, hold in PRESENT until downstream acknowledges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      dor_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            dor_r   <= 1'b1;
            state_r <= PRESENT;
          end else begin
            dor_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        PRESENT: begin
          if (ack_from_next) begin
            dor_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            dor_r   <= 1'b1;
            state_r <= PRESENT;
          end
        end
        default: begin
          dor_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // data_out is built only from registers: the popped head and DOR, so it
  // changes on the pop edge together with DOR and reads 0 whenever DOR is 0.
  assign data_out = dor_r ? scale(head_s) : {WIDTH{1'b0}};
  assign ack_prev = ack_prev_r;
  assign DOR      = dor_r;
  assign level    = level_s;

endmodule

// File: tb/tb_stage_c.sv
// Directed self-checking bench for stage_c (WIDTH=8, DEPTH=4, SCALE=2).
module tb_stage_c;

  logic       clk;
  logic       reset;
  logic       DIR;
  logic [7:0] data_in;
  logic       ack_prev;
  logic       DOR;
  logic [7:0] data_out;
  logic       ack_from_next;
  logic [2:0] level;

  int n_checks;
  int n_errors;
  int cyc;
  int sink_mode;    // 0: bench drives ack, 1: reactive ack, 2: ack tied 1
  int max_level;
  int rx_q[$];
  int rx_cyc[$];

  stage_c #(.WIDTH(8), .DEPTH(4), .SCALE(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .DIR           (DIR),
    .data_in       (data_in),
    .ack_prev      (ack_prev),
    .DOR           (DOR),
    .data_out      (data_out),
    .ack_from_next (ack_from_next),
    .level         (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Downstream model, sampled on the falling edge.
  always begin
    @(negedge clk);
    if (sink_mode == 2) begin
      ack_from_next = 1'b1;
      if (DOR) begin
        rx_q.push_back(int'(data_out));
        rx_cyc.push_back(cyc);
      end
    end else if (sink_mode == 1) begin
      if (DOR && !ack_from_next) begin
        rx_q.push_back(int'(data_out));
        rx_cyc.push_back(cyc);
        ack_from_next = 1'b1;
      end else begin
        ack_from_next = 1'b0;
      end
    end
    if (int'(level) > max_level) max_level = int'(level);
  end

  // stage_B-style producer: raise DIR, wait for ack, drop DIR an edge later.
  // Called at a falling edge, returns at a falling edge.
  task automatic push_item(input logic [7:0] v);
    int n;
    DIR = 1'b1;
    data_in = v;
    n = 0;
    while (ack_prev !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_ack", int'(ack_prev), 1);
    @(negedge clk);
    DIR = 1'b0;
  endtask

  task automatic wait_rx(input int cnt);
    int n;
    n = 0;
    while (rx_q.size() < cnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_count", rx_q.size(), cnt);
  endtask

  task automatic idle_sink();
    repeat (3) @(negedge clk);
    sink_mode = 0;
    ack_from_next = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int acks;
    int exp_sat;
    n_checks = 0; n_errors = 0; cyc = 0; sink_mode = 0; max_level = 0;
    reset = 1'b1; DIR = 1'b0; data_in = 8'd0; ack_from_next = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_ack_prev", int'(ack_prev), 0);
    check_eq("rst_dor", int'(DOR), 0);
    check_eq("rst_data_out", int'(data_out), 0);
    check_eq("rst_level", int'(level), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single item: ack one cycle after capture, DOR one cycle later
    DIR = 1'b1; data_in = 8'd5;
    @(negedge clk);
    check_eq("t1_ack", int'(ack_prev), 1);
    check_eq("t1_dor_early", int'(DOR), 0);
    @(negedge clk);
    check_eq("t1_ack_drop", int'(ack_prev), 0);
    check_eq("t1_dor", int'(DOR), 1);
    check_eq("t1_data", int'(data_out), 10);
    DIR = 1'b0;
    ack_from_next = 1'b1;
    @(negedge clk);
    ack_from_next = 1'b0;
    check_eq("t1_dor_off", int'(DOR), 0);
    check_eq("t1_data_off", int'(data_out), 0);
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_prev) acks++;
    end
    check_eq("t1_single_ack", acks, 0);

    // Fill with downstream stalled, then drain in order
    for (int i = 1; i <= 5; i++) push_item(8'(i));
    check_eq("t2_dor", int'(DOR), 1);
    check_eq("t2_head", int'(data_out), 2);
    check_eq("t2_level_full", int'(level), 4);
    fork
      push_item(8'd6);
    join_none
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack_prev) acks++;
    end
    check_eq("t2_full_no_ack", acks, 0);
    check_eq("t2_level_hold", int'(level), 4);
    rx_q.delete(); rx_cyc.delete();
    sink_mode = 1;
    wait_rx(6);
    wait fork;
    for (int i = 0; i < 6 && i < rx_q.size(); i++)
      check_eq($sformatf("t2_order%0d", i), rx_q[i], 2 * (i + 1));
    for (int i = 1; i < 6 && i < rx_cyc.size(); i++)
      check_eq($sformatf("t2_space%0d", i), rx_cyc[i] - rx_cyc[i-1], 2);
    idle_sink();

    // Push on the same edge as a pop with level=2
    push_item(8'd10); push_item(8'd11); push_item(8'd12);
    check_eq("t3_level_pre", int'(level), 2);
    check_eq("t3_data_pre", int'(data_out), 20);
    ack_from_next = 1'b1;
    @(negedge clk);
    ack_from_next = 1'b0;
    DIR = 1'b1; data_in = 8'd13;
    @(negedge clk);
    check_eq("t3_level_same", int'(level), 2);
    check_eq("t3_ack", int'(ack_prev), 1);
    check_eq("t3_old_head", int'(data_out), 22);
    @(negedge clk);
    DIR = 1'b0;
    rx_q.delete(); rx_cyc.delete();
    sink_mode = 1;
    wait_rx(3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      check_eq($sformatf("t3_order%0d", i), rx_q[i], 22 + 2 * i);

    // Scaling overflow
    rx_q.delete(); rx_cyc.delete();
`ifdef STAGE_C_SATURATE_EN
    exp_sat = 255;
`else
    exp_sat = 144;
`endif
    push_item(8'd200);
    push_item(8'd100);
    wait_rx(2);
    if (rx_q.size() >= 2) begin
      check_eq("t4_200x2", rx_q[0], exp_sat);
      check_eq("t4_100x2", rx_q[1], 200);
    end
    idle_sink();

    // Asynchronous reset mid-cycle with DOR=1 and level=3
    for (int i = 1; i <= 4; i++) push_item(8'(i));
    check_eq("t5_dor_pre", int'(DOR), 1);
    check_eq("t5_level_pre", int'(level), 3);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_dor", int'(DOR), 0);
    check_eq("t5_data", int'(data_out), 0);
    check_eq("t5_ack", int'(ack_prev), 0);
    check_eq("t5_level", int'(level), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack_prev || DOR || data_out != 8'd0 || level != 3'd0) acks++;
    end
    check_eq("t5_quiet_after", acks, 0);

    // Back-to-back stream with ack tied high
    rx_q.delete(); rx_cyc.delete();
    max_level = 0;
    sink_mode = 2;
    for (int i = 0; i < 8; i++) push_item(8'(9 * i + 3));
    wait_rx(8);
    repeat (3) @(negedge clk);
    check_eq("t6_no_dup", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check_eq($sformatf("t6_item%0d", i), rx_q[i], 2 * (9 * i + 3));
    check_eq("t6_level_le1", int'(max_level <= 1), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
